// File: rtl/arith_pkg.sv
// Shared arithmetic defaults and the FSM state encoding for the
// byte-serial adder/subtractor.
package arith_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int SLICE_DEF  = 8;
    localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla8_slice.sv
// 8-bit two-level carry-lookahead slice: two 4-bit lookahead groups
// joined by a group-level lookahead stage.
module cla8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       c7
);

    logic [7:0] p, g, c;
    logic [1:0] gg, gp;
    logic       c4;

    assign p = a ^ b;
    assign g = a & b;

    // Group generate/propagate for bits 3:0 and 7:4.
    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < 2; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    assign c4   = gg[0] | (gp[0] & cin);
    assign cout = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);

    always_comb begin
        logic gc;
        c = '0;
        for (int k = 0; k < 2; k++) begin
            gc         = (k == 0) ? cin : c4;
            c[4*k]     = gc;
            c[4*k + 1] = g[4*k] | (p[4*k] & gc);
            c[4*k + 2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                       | (p[4*k+1] & p[4*k] & gc);
            c[4*k + 3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                       | (p[4*k+2] & p[4*k+1] & g[4*k])
                       | (p[4*k+2] & p[4*k+1] & p[4*k] & gc);
        end
    end

    assign s  = p ^ c;
    assign c7 = c[7];

endmodule

// File: rtl/serial_addsub32.sv
// Byte-serial adder/subtractor: one lookahead slice per cycle, LSB first,
// with the inter-slice carry held in a register.
module serial_addsub32
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF   // the slice adder is 8 bits wide
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, sum_nxt;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [SLICE-1:0] sl_a, sl_b, sl_s;
    logic             sl_cout, sl_c7;
    logic             accept, fire, last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;
    assign last      = (state == BUSY) && (idx == IDXW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last)   state_nxt = DONE;
            DONE:    if (fire)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sl_a    = op_a[int'(idx)*SLICE +: SLICE];
        sl_b    = op_b[int'(idx)*SLICE +: SLICE];
        sum_nxt = sum;
        sum_nxt[int'(idx)*SLICE +: SLICE] = sl_s;
    end

    cla8_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_cout),
        .c7   (sl_c7)
    );

    // Subtraction is A + ~B + 1: B is inverted at capture and the +1
    // enters as the initial slice carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
        end else if (state == BUSY) begin
            sum   <= sum_nxt;
            carry <= sl_cout;
            if (last) begin
                idx  <= '0;
                cout <= sl_cout;
                ovf  <= sl_c7 ^ sl_cout;
                zero <= (sum_nxt == '0);
            end else begin
                idx  <= idx + IDXW'(1);
            end
        end
    end

endmodule
